// File: rtl/alu_ram_regfile_pkg.sv
// Shared constants for alu_ram_regfile: ALU op codes, flag bit positions, default widths.
package alu_ram_regfile_pkg;

  localparam int DEFAULT_DW     = 4;
  localparam int DEFAULT_RF_AW  = 3;
  localparam int DEFAULT_RAM_AW = 4;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_SAR  = 4'd8,
    OP_PASS = 4'd9,
    OP_INC  = 4'd10,
    OP_DEC  = 4'd11
  } alu_op_e;

endpackage

// File: rtl/arr_alu.sv
// Combinational ALU with {V,C,N,Z} flags.
// Shift ops 6-8 are present only when macro ALU_SHIFT_EN is defined; otherwise they yield 0.
module arr_alu
  import alu_ram_regfile_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic [3:0]    flags
);

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] result_s;
  logic          carry_s;
  logic          ovf_s;
  logic [DW:0]   sum_s;
  logic [DW:0]   diff_s;

  // Result, carry and overflow selection; operands are zero-extended so bit DW is carry/borrow
  always_comb begin
    result_s = {DW{1'b0}};
    carry_s  = 1'b0;
    ovf_s    = 1'b0;
    sum_s    = {(DW+1){1'b0}};
    diff_s   = {(DW+1){1'b0}};
    case (alu_op_e'(op))
      OP_ADD: begin
        sum_s    = {1'b0, a} + {1'b0, b};
        result_s = sum_s[DW-1:0];
        carry_s  = sum_s[DW];
        ovf_s    = (a[DW-1] == b[DW-1]) && (result_s[DW-1] != a[DW-1]);
      end
      OP_SUB: begin
        diff_s   = {1'b0, a} - {1'b0, b};
        result_s = diff_s[DW-1:0];
        carry_s  = ~diff_s[DW];
        ovf_s    = (a[DW-1] != b[DW-1]) && (result_s[DW-1] != a[DW-1]);
      end
      OP_AND:  result_s = a & b;
      OP_OR:   result_s = a | b;
      OP_XOR:  result_s = a ^ b;
      OP_NOT:  result_s = ~a;
`ifdef ALU_SHIFT_EN
      OP_SHL: begin
        result_s = {a[DW-2:0], 1'b0};
        carry_s  = a[DW-1];
      end
      OP_SHR: begin
        result_s = {1'b0, a[DW-1:1]};
        carry_s  = a[0];
      end
      OP_SAR: begin
        result_s = {a[DW-1], a[DW-1:1]};
        carry_s  = a[0];
      end
`else
      OP_SHL, OP_SHR, OP_SAR: result_s = {DW{1'b0}};
`endif
      OP_PASS: result_s = b;
      OP_INC: begin
        sum_s    = {1'b0, a} + {1'b0, ONE};
        result_s = sum_s[DW-1:0];
        carry_s  = sum_s[DW];
        ovf_s    = ~a[DW-1] && result_s[DW-1];
      end
      OP_DEC: begin
        diff_s   = {1'b0, a} - {1'b0, ONE};
        result_s = diff_s[DW-1:0];
        carry_s  = ~diff_s[DW];
        ovf_s    = a[DW-1] && ~result_s[DW-1];
      end
      default: result_s = {DW{1'b0}};
    endcase
  end

  // Flag packing derived from the selected result
  always_comb begin
    flags         = 4'b0000;
    flags[FLAG_Z] = (result_s == {DW{1'b0}});
    flags[FLAG_N] = result_s[DW-1];
    flags[FLAG_C] = carry_s;
    flags[FLAG_V] = ovf_s;
  end

  assign result = result_s;

endmodule

// File: rtl/alu_ram_regfile.sv
// Register file (combinational reads, async reset), registered-read RAM and the arr_alu datapath.
// Optional shift ops in arr_alu are enabled by macro ALU_SHIFT_EN.
module alu_ram_regfile
  import alu_ram_regfile_pkg::*;
#(
  parameter int DW     = DEFAULT_DW,
  parameter int RF_AW  = DEFAULT_RF_AW,
  parameter int RAM_AW = DEFAULT_RAM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RF_AW-1:0]  ra1,
  input  logic [RF_AW-1:0]  ra2,
  output logic [DW-1:0]     rd1,
  output logic [DW-1:0]     rd2,
  input  logic              reg_we,
  input  logic [RF_AW-1:0]  wa,
  input  logic [DW-1:0]     wd,
  input  logic [3:0]        alu_op,
  input  logic [DW-1:0]     alu_a,
  input  logic [DW-1:0]     alu_b,
  output logic [DW-1:0]     alu_result,
  output logic [3:0]        alu_flags,
  input  logic              ram_we,
  input  logic [RAM_AW-1:0] ram_waddr,
  input  logic [RAM_AW-1:0] ram_raddr,
  input  logic [DW-1:0]     ram_wdata,
  output logic [DW-1:0]     ram_q
);

  localparam int RF_DEPTH  = 2 ** RF_AW;
  localparam int RAM_DEPTH = 2 ** RAM_AW;

  logic [DW-1:0] regs_r [RF_DEPTH];
  logic [DW-1:0] mem_r  [RAM_DEPTH];
  logic [DW-1:0] ram_q_r;

  // Register file storage; every entry writable, cleared while rst is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
    end else if (reg_we) begin
      regs_r[wa] <= wd;
    end
  end

  assign rd1 = regs_r[ra1];
  assign rd2 = regs_r[ra2];

  // RAM array is deliberately not reset; writes are blocked while rst is high
  always_ff @(posedge clk) begin
    if (!rst && ram_we) begin
      mem_r[ram_waddr] <= ram_wdata;
    end
  end

  // Registered RAM read; samples pre-write contents so same-address read returns old data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_q_r <= {DW{1'b0}};
    end else begin
      ram_q_r <= mem_r[ram_raddr];
    end
  end

  assign ram_q = ram_q_r;

  arr_alu #(
    .DW(DW)
  ) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .flags  (alu_flags)
  );

endmodule

// File: tb/tb_alu_ram_regfile.sv
// Directed self-checking bench for alu_ram_regfile (expectations follow ALU_SHIFT_EN if defined).
module tb_alu_ram_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ra1, ra2, wa;
  logic [3:0] rd1, rd2, wd;
  logic       reg_we;
  logic [3:0] alu_op, alu_a, alu_b, alu_result, alu_flags;
  logic       ram_we;
  logic [3:0] ram_waddr, ram_raddr, ram_wdata, ram_q;

  int errors = 0;
  int checks = 0;

  alu_ram_regfile dut (
    .clk(clk), .rst(rst),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .reg_we(reg_we), .wa(wa), .wd(wd),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply an ALU vector and compare result and {V,C,N,Z}
  task automatic alu_chk(input string tag, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] res, input logic [3:0] fl);
    alu_op = op; alu_a = a; alu_b = b;
    #1;
    check({tag, "_res"}, {4'h0, alu_result}, {4'h0, res});
    check({tag, "_flg"}, {4'h0, alu_flags}, {4'h0, fl});
  endtask

  initial begin
    rst = 1'b1; ra1 = 3'd0; ra2 = 3'd0; wa = 3'd0; wd = 4'h0; reg_we = 1'b0;
    alu_op = 4'd0; alu_a = 4'h0; alu_b = 4'h0;
    ram_we = 1'b0; ram_waddr = 4'h0; ram_raddr = 4'h0; ram_wdata = 4'h0;

    // Reset state: every register reads 0, ram_q is 0
    #1;
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); ra2 = 3'(7 - i);
      #1;
      check($sformatf("rst_rd1_%0d", i), {4'h0, rd1}, 8'h00);
      check($sformatf("rst_rd2_%0d", i), {4'h0, rd2}, 8'h00);
    end
    check("rst_ram_q", {4'h0, ram_q}, 8'h00);

    // Register write attempted during reset is ignored
    @(negedge clk); reg_we = 1'b1; wa = 3'd1; wd = 4'h5; ra1 = 3'd1;
    @(posedge clk); #1;
    check("rst_write_ignored", {4'h0, rd1}, 8'h00);
    @(negedge clk); rst = 1'b0; reg_we = 1'b0;

    // Same-cycle read returns old value, new value visible next cycle
    @(negedge clk); reg_we = 1'b1; wa = 3'd3; wd = 4'hA; ra1 = 3'd3; ra2 = 3'd5;
    #1;
    check("rf_same_cycle", {4'h0, rd1}, 8'h00);
    @(posedge clk); #1;
    check("rf_next_cycle", {4'h0, rd1}, 8'h0A);
    check("rf_other_reg", {4'h0, rd2}, 8'h00);
    @(negedge clk); wa = 3'd0; wd = 4'h7; ra2 = 3'd0;
    @(posedge clk); #1;
    check("rf_reg0_writable", {4'h0, rd2}, 8'h07);
    check("rf_reg3_kept", {4'h0, rd1}, 8'h0A);
    @(negedge clk); reg_we = 1'b0;

    // ALU directed vectors; flags are {V,C,N,Z}
    alu_chk("add_7_1",  4'd0,  4'h7, 4'h1, 4'h8, 4'b1010);
    alu_chk("add_f_1",  4'd0,  4'hF, 4'h1, 4'h0, 4'b0101);
    alu_chk("sub_3_5",  4'd1,  4'h3, 4'h5, 4'hE, 4'b0010);
    alu_chk("sub_5_5",  4'd1,  4'h5, 4'h5, 4'h0, 4'b0101);
    alu_chk("sub_8_1",  4'd1,  4'h8, 4'h1, 4'h7, 4'b1100);
    alu_chk("and",      4'd2,  4'hC, 4'hA, 4'h8, 4'b0010);
    alu_chk("or",       4'd3,  4'h5, 4'hA, 4'hF, 4'b0010);
    alu_chk("xor",      4'd4,  4'hF, 4'hF, 4'h0, 4'b0001);
    alu_chk("not",      4'd5,  4'h5, 4'h0, 4'hA, 4'b0010);
    alu_chk("pass",     4'd9,  4'hF, 4'h3, 4'h3, 4'b0000);
    alu_chk("inc_f",    4'd10, 4'hF, 4'h0, 4'h0, 4'b0101);
    alu_chk("inc_7",    4'd10, 4'h7, 4'h0, 4'h8, 4'b1010);
    alu_chk("dec_0",    4'd11, 4'h0, 4'h0, 4'hF, 4'b0010);
    alu_chk("dec_8",    4'd11, 4'h8, 4'h0, 4'h7, 4'b1100);
    alu_chk("op12",     4'd12, 4'hF, 4'hF, 4'h0, 4'b0001);
    alu_chk("op15",     4'd15, 4'h7, 4'h1, 4'h0, 4'b0001);
`ifdef ALU_SHIFT_EN
    alu_chk("shr_9",    4'd7,  4'h9, 4'h0, 4'h4, 4'b0100);
    alu_chk("shl_9",    4'd6,  4'h9, 4'h0, 4'h2, 4'b0100);
    alu_chk("sar_9",    4'd8,  4'h9, 4'h0, 4'hC, 4'b0110);
`else
    alu_chk("shr_9",    4'd7,  4'h9, 4'h0, 4'h0, 4'b0001);
    alu_chk("shl_9",    4'd6,  4'h9, 4'h0, 4'h0, 4'b0001);
    alu_chk("sar_9",    4'd8,  4'h9, 4'h0, 4'h0, 4'b0001);
`endif

    // RAM: write 9=6, then read it back one cycle after the address is sampled
    @(negedge clk); ram_we = 1'b1; ram_waddr = 4'd9; ram_wdata = 4'h6; ram_raddr = 4'd0;
    @(negedge clk); ram_we = 1'b1; ram_waddr = 4'd4; ram_wdata = 4'h3; ram_raddr = 4'd9;
    @(posedge clk); #1;
    check("ram_read_9", {4'h0, ram_q}, 8'h06);
    // Same-edge write and read of address 9 returns old data
    @(negedge clk); ram_we = 1'b1; ram_waddr = 4'd9; ram_wdata = 4'h2; ram_raddr = 4'd9;
    @(posedge clk); #1;
    check("ram_rdw_old", {4'h0, ram_q}, 8'h06);
    @(negedge clk); ram_we = 1'b0; ram_raddr = 4'd9;
    @(posedge clk); #1;
    check("ram_rdw_new", {4'h0, ram_q}, 8'h02);
    @(negedge clk); ram_raddr = 4'd4;
    @(posedge clk); #1;
    check("ram_read_4", {4'h0, ram_q}, 8'h03);

    // Asynchronous reset mid-cycle clears ram_q and the register file
    @(negedge clk); ra1 = 3'd3; #1;
    check("pre_rst_rd1", {4'h0, rd1}, 8'h0A);
    rst = 1'b1; #1;
    check("async_rst_rd1", {4'h0, rd1}, 8'h00);
    check("async_rst_ram_q", {4'h0, ram_q}, 8'h00);
    @(negedge clk); rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ram_regfile.md
ALU_RAM_REGFILE -- requirements
Module: alu_ram_regfile

Interface
REQ-001 SHALL have parameter DW, default 4: data word width; all data ports are DW bits.
REQ-002 SHALL have parameter RF_AW, default 3: register-file address width (8 entries).
REQ-003 SHALL have parameter RAM_AW, default 4: RAM address width (16 entries).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports ra1, ra2  in  RF_AW  register read addresses; rd1, rd2  out  DW  read data.
REQ-007 SHALL have ports reg_we  in  1  register write enable; wa  in  RF_AW  write address; wd  in  DW  write data.
REQ-008 SHALL have ports alu_op  in  4  operation select; alu_a, alu_b  in  DW  operands.
REQ-009 SHALL have ports alu_result  out  DW  result; alu_flags  out  4  flags {V,C,N,Z}, with Z at bit 0.
REQ-010 SHALL have ports ram_we  in  1; ram_waddr, ram_raddr  in  RAM_AW; ram_wdata  in  DW; ram_q  out  DW.

Function
REQ-011 Register file SHALL hold 2^RF_AW words; reads are combinational and independent; all entries are writable (no hardwired zero).
REQ-012 Register write SHALL occur at the clk edge when reg_we=1; a same-cycle read of wa returns the old value, and the new value is visible from the next cycle.
REQ-013 ALU SHALL be purely combinational (0-cycle latency); results SHALL wrap modulo 2^DW.
REQ-014 ALU ops: 0 ADD; 1 SUB (a-b); 2 AND; 3 OR; 4 XOR; 5 NOT a; 6 SHL a by 1; 7 SHR a by 1 (logical); 8 SAR a by 1; 9 PASS b; 10 INC a; 11 DEC a; 12-15 result 0.
REQ-015 Z SHALL be 1 iff result==0; N SHALL equal result MSB for every op.
REQ-016 C SHALL be the carry-out for ADD and INC; for SUB and DEC, C=1 means no borrow (a>=b unsigned); for shifts, C is the bit shifted out; C=0 otherwise.
REQ-017 V SHALL flag signed overflow for ADD, SUB, INC and DEC; V=0 for all other ops.
REQ-018 RAM SHALL hold 2^RAM_AW words; write occurs at the clk edge when ram_we=1.
REQ-019 RAM read SHALL be registered: ram_q shows mem[ram_raddr] one cycle after the address is sampled (1-cycle latency).
REQ-020 On a same-edge read and write to the same RAM address, ram_q SHALL return the old data.
REQ-021 RAM write and read ports SHALL be fully independent; different addresses have no interaction.

Reset
REQ-022 While rst=1, all register-file entries SHALL be 0 and ram_q SHALL be 0, asynchronously.
REQ-023 RAM array contents SHALL NOT be reset; reads of never-written RAM locations are undefined.
REQ-024 Writes SHALL be ignored while rst=1; the first write takes effect at the first clk edge after rst deasserts.

Configuration
REQ-025 Macro ALU_SHIFT_EN: when defined, ops 6-8 SHALL behave per REQ-014 and REQ-016.
REQ-026 When ALU_SHIFT_EN is undefined, ops 6-8 SHALL produce result 0 with flags Z=1, N=0, C=0, V=0.

Structure
REQ-027 Package alu_ram_regfile_pkg SHALL hold the ALU op-code constants/enum, the flag bit indices (Z=0, N=1, C=2, V=3) and the default widths.
REQ-028 The ALU SHALL be a separate combinational sub-module named arr_alu; the register file and RAM are inline in the top.

Verification
REQ-029 rst pulse, then read all 8 registers -> all rd1/rd2 = 0; ram_q = 0.
REQ-030 Write reg 3=0xA with reg_we=1; in the same cycle ra1=3 -> rd1=0x0; on the next cycle rd1=0xA; in parallel, ra2=5 -> rd2 unchanged.
REQ-031 ADD 0x7+0x1 -> result 0x8, flags N=1, V=1, C=0, Z=0; ADD 0xF+0x1 -> result 0x0, Z=1, C=1, V=0.
REQ-032 SUB 0x3-0x5 -> result 0xE, C=0, N=1; SUB 0x5-0x5 -> result 0x0, Z=1, C=1.
REQ-033 RAM: write addr 9=0x6, then read addr 9 -> ram_q=0x6 one cycle later; same-edge write 9=0x2 with read 9 -> ram_q=0x6, then 0x2 on the next read.
REQ-034 SHR 0x9 -> result 0x4, C=1 with ALU_SHIFT_EN defined; same stimulus without the macro -> result 0x0, Z=1.
